// File: rtl/quantum_op_arbiter.sv
// quantum_op_arbiter
//   Round-robin arbiter and sequencer in front of the single quantum operation
//   controller. Each requester owns one holding slot (op code + 16-bit param).
//   Pending slots are issued one at a time. Each attempt is guarded by a
//   watchdog, a ctl_error triggers a bounded number of re-issues, and every
//   slot finishes with a tagged response.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   req_valid/ready   : per-requester submit handshake; ready = slot empty
//   req_op/req_param  : packed per-requester op code (4b) and parameter (16b)
//   ctl_op_code/param : op presented to the controller, held ISSUE..RESP
//   ctl_start         : one-cycle start pulse per attempt
//   ctl_done/error    : controller completion / failure (sampled in WAIT only)
//   ctl_result        : controller result, latched on clean completion
//   gnt               : one-hot requester being served
//   busy              : arbiter not idle
//   rsp_*             : response strobe plus id/err/timeout/retries/result
module quantum_op_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [16*NREQ-1:0]   req_param,
  output logic [3:0]           ctl_op_code,
  output logic [15:0]          ctl_param,
  output logic                 ctl_start,
  input  logic                 ctl_done,
  input  logic                 ctl_error,
  input  logic [15:0]          ctl_result,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic [1:0]           rsp_retries,
  output logic [15:0]          rsp_result
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [NREQ-1:0] pending;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  sel;
  logic [15:0]     timer;
  logic [1:0]      retry_cnt;

  logic [3:0]      slot_op    [NREQ];
  logic [15:0]     slot_param [NREQ];

  logic [IDW-1:0]  pick;
  logic            found;
  int              idx;

  assign req_ready = ~pending;

  // Slot payload needs no reset: it is only read while its pending bit is set.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (req_valid[gi] && !pending[gi]) begin
          slot_op[gi]    <= req_op[4*gi +: 4];
          slot_param[gi] <= req_param[16*gi +: 16];
        end
      end
    end
  endgenerate

  // First pending slot at or after ptr, wrapping modulo NREQ.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  function automatic logic op_ok(input logic [3:0] op);
    return (op != 4'd0) && (op <= 4'd6);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      ptr         <= '0;
      sel         <= '0;
      timer       <= '0;
      retry_cnt   <= '0;
      ctl_op_code <= '0;
      ctl_param   <= '0;
      ctl_start   <= 1'b0;
      gnt         <= '0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_retries <= '0;
      rsp_result  <= '0;
    end else begin
      ctl_start <= 1'b0;
      rsp_valid <= 1'b0;

      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !pending[i]) pending[i] <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (found) begin
            sel       <= pick;
            gnt       <= NREQ'(1) << pick;
            busy      <= 1'b1;
            retry_cnt <= '0;
            if (op_ok(slot_op[pick])) begin
              state       <= ISSUE;
              ctl_start   <= 1'b1;
              ctl_op_code <= slot_op[pick];
              ctl_param   <= slot_param[pick];
              timer       <= '0;
            end else begin
              // Unsupported op code: answer with an error, never start.
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_id      <= pick;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_retries <= '0;
              rsp_result  <= '0;
            end
          end
        end

        ISSUE: begin
          state <= WAIT;
          timer <= '0;
        end

        WAIT: begin
          timer <= timer + 16'd1;
          if (ctl_error) begin
            if (32'(retry_cnt) < MAX_RETRY) begin
              retry_cnt <= retry_cnt + 2'd1;
              state     <= ISSUE;
              ctl_start <= 1'b1;
            end else begin
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_id      <= sel;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_retries <= retry_cnt;
              rsp_result  <= '0;
            end
          end else if (ctl_done) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_id      <= sel;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_retries <= retry_cnt;
            rsp_result  <= ctl_result;
          end else if (timer == 16'(TIMEOUT - 1)) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_id      <= sel;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_retries <= retry_cnt;
            rsp_result  <= '0;
          end
        end

        RESP: begin
          // sel is pending here, so no accept can collide with this clear.
          pending[sel] <= 1'b0;
          ptr          <= (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
          state        <= IDLE;
          gnt          <= '0;
          busy         <= 1'b0;
          ctl_op_code  <= '0;
          ctl_param    <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/quantum_op_arbiter.md
Name: quantum_op_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single quantum operation controller between NREQ requesters (CPU issue unit, DMA, debug port, etc.).
- Each requester deposits one operation (op code plus 16-bit parameter) into a private holding slot.
- The arbiter issues slot contents to the controller one at a time, waits for completion with a watchdog, retries on error, and returns a tagged response.
- Sits between the requesters and quantum_controller's op_code/op_param/op_start/op_done/op_error/op_result interface.

Parameters:
NREQ, 4, number of requesters (2..4)
IDW, 2, requester-id width
TIMEOUT, 255, WAIT-state cycles before abort (1..65535, 16-bit timer)
MAX_RETRY, 2, re-issues allowed after ctl_error (0..3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NREQ  per-requester submit strobe
req_ready  out  NREQ  slot i empty; transfer when valid&ready
req_op  in  4*NREQ  op code of requester i at [4i+3:4i]
req_param  in  16*NREQ  parameter of requester i at [16i+15:16i]
ctl_op_code  out  4  op code to controller
ctl_param  out  16  parameter to controller (param bytes 1:0)
ctl_start  out  1  one-cycle start pulse
ctl_done  in  1  controller completion
ctl_error  in  1  controller error
ctl_result  in  16  controller result bytes 1:0
gnt  out  NREQ  one-hot, requester currently being served
busy  out  1  state != IDLE
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  IDW  requester index of the response
rsp_err  out  1  operation failed
rsp_timeout  out  1  failure caused by watchdog
rsp_retries  out  2  re-issues used
rsp_result  out  16  latched ctl_result (0 on error)

Behaviour:
- Reset (async): state=IDLE, pending=0, ptr=0, timer=0, retry_cnt=0. All outputs 0 except req_ready = all 1s. A reset mid-operation drops all pending slots; requesters must resubmit.
- Slots: on req_valid[i]&req_ready[i] at an edge, latch op/param into slot i and set pending[i]. req_ready[i] = !pending[i]. req_valid while not ready is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any pending, select the first pending index searching ptr, ptr+1, ... with wrap mod NREQ. Latch sel, drive gnt, clear retry_cnt.
  - If the slot op is valid (0001..0110), go to ISSUE.
  - Otherwise (0000 or 0111..1111), go to RESP with rsp_err=1 and no ctl_start.
- ISSUE: ctl_start=1 for this cycle only. Clear timer. Go to WAIT.
- ctl_op_code/ctl_param: held from ISSUE through RESP; 0 in IDLE.
- WAIT: timer increments each cycle.
  - ctl_error (with or without ctl_done), retry_cnt<MAX_RETRY: retry_cnt++, go to ISSUE.
  - ctl_error, retries exhausted: go to RESP, err=1.
  - ctl_done alone: latch ctl_result, go to RESP, err=0.
  - Neither, timer==TIMEOUT-1: go to RESP, err=1, timeout=1. WAIT therefore lasts at most TIMEOUT cycles per attempt.
- RESP:
  - rsp_valid=1 for one cycle with id, err, timeout, retries, result.
  - Clear pending[sel]; ptr <= (sel+1) mod NREQ; go to IDLE.
  - rsp_* fields hold until the next RESP; rsp_valid and ctl_start are pulses.
- Latency: an accept in cycle N gives ctl_start in cycle N+2. ctl_done in cycle M gives rsp_valid in M+1, and req_ready[sel] high in M+2.
- ctl_done/ctl_error outside WAIT are ignored.
- An accept into another slot may occur in any state. It does not preempt the current op and is considered at the next IDLE.

Test Plan:
- Single op: req_valid[0] cycle 0, op=0011, param=0x0F15 -> ctl_start cycle 2 with op 0011, param 0x0F15. ctl_done, result 0x0503 in cycle 6 -> rsp_valid cycle 7, id=0, err=0, retries=0, result=0x0503. req_ready[0]=1 in cycle 8.
- Fairness: all 4 submit in cycle 0 after reset -> service order 0,1,2,3. Then 0 and 3 resubmit together -> 0 served before 3 (ptr=0).
- Retry, MAX_RETRY=2:
  - ctl_error on attempts 1 and 2, ctl_done on 3 -> three ctl_start pulses, rsp err=0, retries=2.
  - ctl_error on all three attempts -> rsp err=1, retries=2, result=0.
- Timeout, TIMEOUT=8: ctl_start cycle 2, no ctl_done -> rsp_valid cycle 11, err=1, timeout=1. A late ctl_done in cycle 12 is ignored.
- Invalid op 1001 submitted cycle 0 -> no ctl_start, rsp_valid cycle 2, err=1, timeout=0.
- Reset mid-WAIT with slots 1 and 2 pending:
  - During reset -> all outputs 0, req_ready=1111.
  - After release -> ctl_done pulse ignored, no rsp_valid, state stays IDLE.
